pipeline_mem_arbiter: RTL and testbench

Shares one single-port memory between the pipelined CPU's instruction-fetch (IF) port and its data-memory (DM) stage port. It arbitrates requests and sequences the memory handshake, and returns read data to the winning requester. It gives each stage an ack/stall indication so the pipeline control can freeze stages while the memory is busy. It sits between the CPU core and the unified memory.

---
 rtl/pipeline_mem_arbiter_pkg.sv | 13 +
 rtl/pipeline_mem_arbiter_if.sv | 52 +++++
 rtl/pipeline_mem_arbiter_timeout_ctr.sv | 27 ++
 rtl/pipeline_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_pipeline_mem_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_mem_arbiter_pkg.sv
// Shared definitions for the pipeline memory arbiter: FSM state encoding and
// default bus widths. Package name pipeline_pkg is kept for existing importers.
package pipeline_pkg;

  localparam int unsigned AW_DEF = 16;
  localparam int unsigned DW_DEF = 32;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_GRANT_I = 2'd1;
  localparam logic [1:0] ARB_GRANT_D = 2'd2;
  localparam logic [1:0] ARB_RESP    = 2'd3;

endpackage

// File: rtl/pipeline_mem_arbiter_if.sv
// Bus bundle between CPU fetch/data ports, the arbiter and the unified memory.
// slave: the arbiter's view; master: the surrounding core/memory view.
interface pipeline_mem_arbiter_if
  import pipeline_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          if_stall;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          dm_stall;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  logic          err;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack, if_stall,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output err
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack, if_stall,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  err
  );

endinterface

// File: rtl/pipeline_mem_arbiter_timeout_ctr.sv
// Grant-phase watchdog: counts cycles without mem_ack; expired flags the
// TIMEOUT-th such cycle so the arbiter can abort on that edge.
module arb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int unsigned CW = (TIMEOUT > 16) ? $clog2(TIMEOUT) : 4;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LIM);

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Single-port memory arbiter for IF and DM pipeline ports, DM priority.
// Optional IF starvation guard enabled by defining ARB_FAIR_EN.
module pipeline_mem_arbiter
  import pipeline_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned TIMEOUT = 15
`ifdef ARB_FAIR_EN
  ,
  parameter int unsigned MAX_SKIP = 3
`endif
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_mem_arbiter_if.slave bus
);

  logic [1:0]    state;
  logic          mem_req_q, mem_we_q, if_ack_q, dm_ack_q, err_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;

  logic          granted, tmo_clear, tmo_en, tmo_expired;
  logic          timed_out, done, pick_d;
  logic [DW-1:0] rsp_data;

  arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    granted   = (state == ARB_GRANT_I) || (state == ARB_GRANT_D);
    tmo_clear = (state == ARB_IDLE);
    tmo_en    = granted && !bus.mem_ack;
    // A real ack in the expiry cycle still wins over the abort.
    timed_out = granted && !bus.mem_ack && tmo_expired;
    done      = (granted && bus.mem_ack) || timed_out;
    rsp_data  = (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;
  end

`ifdef ARB_FAIR_EN
  localparam int unsigned SW = (MAX_SKIP > 0) ? $clog2(MAX_SKIP + 1) : 1;
  localparam logic [SW-1:0] SKIP_LIM = SW'(MAX_SKIP);
  logic [SW-1:0] skip_q;

  always_comb pick_d = bus.dm_req && !(bus.if_req && (skip_q == SKIP_LIM));
`else
  always_comb pick_d = bus.dm_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ARB_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
`ifdef ARB_FAIR_EN
      skip_q      <= '0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_d) begin
            state       <= ARB_GRANT_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
`ifdef ARB_FAIR_EN
            if (bus.if_req) skip_q <= skip_q + 1'b1;
`endif
          end else if (bus.if_req) begin
            state       <= ARB_GRANT_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
`ifdef ARB_FAIR_EN
            skip_q      <= '0;
`endif
          end
        end
        ARB_GRANT_I, ARB_GRANT_D: begin
          if (done) begin
            state     <= ARB_RESP;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            err_q     <= timed_out;
            if (state == ARB_GRANT_I) begin
              if_rdata_q <= rsp_data;
              if_ack_q   <= 1'b1;
            end else begin
              dm_rdata_q <= rsp_data;
              dm_ack_q   <= 1'b1;
            end
          end
        end
        default: begin
          state    <= ARB_IDLE;
          if_ack_q <= 1'b0;
          dm_ack_q <= 1'b0;
          err_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.err       = err_q;
  assign bus.if_stall  = bus.if_req & ~if_ack_q;
  assign bus.dm_stall  = bus.dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed self-checking bench for pipeline_mem_arbiter; the arbitration-order
// scenario expects round-robin-ish order when ARB_FAIR_EN is defined.
module tb_pipeline_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipeline_mem_arbiter_if #(.AW(16), .DW(32)) bus ();

  pipeline_mem_arbiter #(
    .AW(16), .DW(32), .TIMEOUT(15)
`ifdef ARB_FAIR_EN
    , .MAX_SKIP(3)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b0;
    step(); step();
    checks++; if ({bus.mem_req, bus.mem_we, bus.if_ack, bus.dm_ack, bus.err} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {bus.mem_req, bus.mem_we, bus.if_ack, bus.dm_ack, bus.err}); end
    checks++; if (bus.mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); end
    checks++; if ({bus.if_rdata, bus.dm_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", {bus.if_rdata, bus.dm_rdata}); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_if_read;
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    #1;
    checks++; if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL if_stall_c0: got %b expected 1", bus.if_stall); end
    step(); // cycle 1: grant
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL if_mem_req: got %b expected 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 16'h0010) begin errors++; $display("FAIL if_mem_addr: got %h expected 0010", bus.mem_addr); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL if_mem_we: got %b expected 0", bus.mem_we); end
    step(); // cycle 2
    checks++; if ({bus.if_ack, bus.if_stall} !== 2'b01) begin errors++; $display("FAIL if_wait_c2: got ack/stall %b expected 01", {bus.if_ack, bus.if_stall}); end
    step(); // cycle 3: memory responds
    checks++; if ({bus.mem_req, bus.if_stall} !== 2'b11) begin errors++; $display("FAIL if_wait_c3: got req/stall %b expected 11", {bus.mem_req, bus.if_stall}); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    step(); // cycle 4: RESP
    bus.mem_ack = 1'b0;
    checks++; if (bus.if_ack !== 1'b1) begin errors++; $display("FAIL if_ack: got %b expected 1", bus.if_ack); end
    checks++; if (bus.if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL if_rdata: got %h expected deadbeef", bus.if_rdata); end
    checks++; if ({bus.if_stall, bus.mem_req, bus.err, bus.dm_ack} !== 4'b0) begin errors++; $display("FAIL if_resp_flags: got %b expected 0000", {bus.if_stall, bus.mem_req, bus.err, bus.dm_ack}); end
    bus.if_req = 1'b0;
    step(); // cycle 5: IDLE
    checks++; if (bus.if_ack !== 1'b0) begin errors++; $display("FAIL if_ack_single: got %b expected 0", bus.if_ack); end
  endtask

  task automatic test_dm_write;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'h0100; bus.dm_wdata = 32'h12345678;
    #1;
    checks++; if (bus.dm_stall !== 1'b1) begin errors++; $display("FAIL dm_stall: got %b expected 1", bus.dm_stall); end
    step();
    checks++; if ({bus.mem_req, bus.mem_we} !== 2'b11) begin errors++; $display("FAIL dmw_req_we: got %b expected 11", {bus.mem_req, bus.mem_we}); end
    checks++; if (bus.mem_addr !== 16'h0100) begin errors++; $display("FAIL dmw_addr: got %h expected 0100", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h12345678) begin errors++; $display("FAIL dmw_wdata: got %h expected 12345678", bus.mem_wdata); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    step();
    bus.mem_ack = 1'b0;
    checks++; if ({bus.dm_ack, bus.if_ack, bus.err} !== 3'b100) begin errors++; $display("FAIL dmw_ack: got dm/if/err %b expected 100", {bus.dm_ack, bus.if_ack, bus.err}); end
    checks++; if (bus.dm_rdata !== 32'h0) begin errors++; $display("FAIL dmw_rdata: got %h expected 0", bus.dm_rdata); end
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    step();
    checks++; if (bus.dm_ack !== 1'b0) begin errors++; $display("FAIL dmw_ack_single: got %b expected 0", bus.dm_ack); end
  endtask

  task automatic test_both_same_cycle;
    int dcnt = 0, icnt = 0, dcyc = -1, icyc = -1;
    logic [31:0] drd = '0, ird = '0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0200;
    bus.if_req = 1'b1; bus.if_addr = 16'h0020;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) begin
        checks++; if (bus.mem_addr !== 16'h0200) begin errors++; $display("FAIL both_first_grant: got addr %h expected 0200", bus.mem_addr); end
      end
      if (bus.dm_ack) begin dcnt++; dcyc = c; drd = bus.dm_rdata; bus.dm_req = 1'b0; end
      if (bus.if_ack) begin icnt++; icyc = c; ird = bus.if_rdata; bus.if_req = 1'b0; end
      bus.mem_ack   = bus.mem_req && !bus.mem_ack;
      bus.mem_rdata = {16'hC0DE, bus.mem_addr};
    end
    bus.mem_ack = 1'b0;
    checks++; if (dcnt !== 1 || dcyc !== 2) begin errors++; $display("FAIL both_dm_ack: got count %0d cycle %0d expected 1 at 2", dcnt, dcyc); end
    checks++; if (icnt !== 1 || icyc !== 5) begin errors++; $display("FAIL both_if_ack: got count %0d cycle %0d expected 1 at 5", icnt, icyc); end
    checks++; if (drd !== 32'hC0DE0200) begin errors++; $display("FAIL both_dm_rdata: got %h expected c0de0200", drd); end
    checks++; if (ird !== 32'hC0DE0020) begin errors++; $display("FAIL both_if_rdata: got %h expected c0de0020", ird); end
  endtask

  task automatic test_timeout;
    int hi = 0;
    int early = 0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0300;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (bus.mem_req) hi++;
      if (bus.dm_ack || bus.err) early++;
    end
    checks++; if (hi !== 15 || early !== 0) begin errors++; $display("FAIL tmo_window: got req cycles %0d early acks %0d expected 15 and 0", hi, early); end
    step(); // cycle 16
    checks++; if ({bus.mem_req, bus.dm_ack, bus.err} !== 3'b011) begin errors++; $display("FAIL tmo_abort: got req/ack/err %b expected 011", {bus.mem_req, bus.dm_ack, bus.err}); end
    checks++; if (bus.dm_rdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata: got %h expected 0", bus.dm_rdata); end
    bus.dm_req = 1'b0;
    step();
    checks++; if ({bus.dm_ack, bus.err, bus.mem_req} !== 3'b0) begin errors++; $display("FAIL tmo_idle: got ack/err/req %b expected 000", {bus.dm_ack, bus.err, bus.mem_req}); end
  endtask

  task automatic test_spurious_ack;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55AA55AA;
    step();
    bus.mem_ack = 1'b0;
    step();
    checks++; if ({bus.if_ack, bus.dm_ack, bus.err, bus.mem_req} !== 4'b0) begin errors++; $display("FAIL spurious_ack: got %b expected 0000", {bus.if_ack, bus.dm_ack, bus.err, bus.mem_req}); end
  endtask

  task automatic test_reset_mid_transfer;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0400;
    step();
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_grant: got %b expected 1", bus.mem_req); end
    reset = 1'b0;
    step();
    checks++; if ({bus.mem_req, bus.mem_we, bus.dm_ack, bus.if_ack, bus.err} !== 5'b0) begin errors++; $display("FAIL rst_mid_flags: got %b expected 00000", {bus.mem_req, bus.mem_we, bus.dm_ack, bus.if_ack, bus.err}); end
    checks++; if ({bus.mem_addr, bus.dm_rdata, bus.if_rdata} !== 80'h0) begin errors++; $display("FAIL rst_mid_regs: got %h expected 0", {bus.mem_addr, bus.dm_rdata, bus.if_rdata}); end
    reset = 1'b1;
    step();
    checks++; if ({bus.mem_req, bus.dm_ack} !== 2'b10) begin errors++; $display("FAIL rst_reissue: got req/ack %b expected 10", {bus.mem_req, bus.dm_ack}); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BADF00D;
    step();
    bus.mem_ack = 1'b0;
    checks++; if (bus.dm_ack !== 1'b1 || bus.dm_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL rst_reissue_ack: got ack %b data %h expected 1 0badf00d", bus.dm_ack, bus.dm_rdata); end
    bus.dm_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back_order;
    logic [7:0] order [8];
    logic [7:0] exp_c;
    int n = 0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0D00;
    bus.if_req = 1'b1; bus.if_addr = 16'h0100;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (bus.dm_ack && n < 8) begin order[n] = "D"; n++; end
      if (bus.if_ack && n < 8) begin order[n] = "I"; n++; end
      bus.mem_ack   = bus.mem_req && !bus.mem_ack;
      bus.mem_rdata = 32'h1;
    end
    bus.dm_req = 1'b0; bus.if_req = 1'b0; bus.mem_ack = 1'b0;
    checks++; if (n !== 8) begin errors++; $display("FAIL order_count: got %0d transfers expected 8", n); end
    for (int i = 0; i < n; i++) begin
`ifdef ARB_FAIR_EN
      exp_c = (i % 4 == 3) ? "I" : "D";
`else
      exp_c = "D";
`endif
      checks++; if (order[i] !== exp_c) begin errors++; $display("FAIL order_%0d: got %c expected %c", i, order[i], exp_c); end
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_write();
    test_both_same_cycle();
    test_timeout();
    test_spurious_ack();
    test_reset_mid_transfer();
    test_back_to_back_order();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
